// File: rtl/frame_shadow_config_mem.sv
// Double-banked tile configuration memory: frames land in a shadow bank and are
// copied to the active bank in one cycle, with readback, sequenced clear and error flag.
module frame_shadow_config_mem #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 640,
  localparam int FrameIdxW      = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       Commit_req,
  output logic                       Commit_ack,
  input  logic                       Clear_req,
  output logic                       Busy,
  input  logic                       Rb_req,
  input  logic [FrameIdxW-1:0]       Rb_frame,
  output logic [FrameBitsPerRow-1:0] Rb_data,
  output logic                       Rb_valid,
  output logic                       Err,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NoConfigBits-1:0]    ConfigBits_N
);

  typedef enum logic [1:0] {StIdle, StCommit, StAck, StClear} stateT;

  stateT                      state, stateNext;
  logic [FrameBitsPerRow-1:0] shadow [MaxFramesPerCol];
  logic [NoConfigBits-1:0]    active;
  logic [NoConfigBits-1:0]    shadowBits;
  logic [FrameIdxW-1:0]       clrIdx;
  logic [FrameBitsPerRow-1:0] rbFrameData;
  logic                       writeEn, strobeErr, clrLast, rbInRange;

  always_ff @(posedge CLK) begin
    if (reset) state <= StIdle;
    else       state <= stateNext;
  end

  // Commit is checked first so a simultaneous clear request is simply dropped.
  always_comb begin
    stateNext = state;
    unique case (state)
      StIdle: begin
        if (Commit_req)     stateNext = StCommit;
        else if (Clear_req) stateNext = StClear;
      end
      StCommit: stateNext = StAck;
      StAck:    if (!Commit_req) stateNext = StIdle;
      StClear:  if (clrLast) stateNext = StIdle;
      default:  stateNext = StIdle;
    endcase
  end

  always_comb begin
    Busy       = 1'b0;
    Commit_ack = 1'b0;
    unique case (state)
      StCommit, StClear: Busy       = 1'b1;
      StAck:             Commit_ack = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    writeEn   = (state == StIdle) && $onehot(FrameStrobe);
    strobeErr = (|FrameStrobe) && !writeEn;
    clrLast   = (32'(clrIdx) == 32'(MaxFramesPerCol - 1));
    rbInRange = (32'(Rb_frame) < 32'(MaxFramesPerCol));
  end

  always_comb begin
    rbFrameData = '0;
    for (int unsigned f = 0; f < MaxFramesPerCol; f++)
      if (32'(Rb_frame) == f) rbFrameData = shadow[f];
  end

  // Flat view of the shadow bank, limited to the bits the tile actually uses.
  always_comb begin
    shadowBits = '0;
    for (int unsigned i = 0; i < NoConfigBits; i++)
      shadowBits[i] = shadow[i / FrameBitsPerRow][i % FrameBitsPerRow];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int unsigned f = 0; f < MaxFramesPerCol; f++) shadow[f] <= '0;
      active   <= '0;
      clrIdx   <= '0;
      Rb_data  <= '0;
      Rb_valid <= 1'b0;
      Err      <= 1'b0;
    end else begin
      // Bits beyond NoConfigBits are never written, so they stay zero and read back as zero.
      for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
        if (writeEn && FrameStrobe[f])
          for (int unsigned b = 0; b < FrameBitsPerRow; b++)
            if (f * FrameBitsPerRow + b < 32'(NoConfigBits)) shadow[f][b] <= FrameData[b];
        if (state == StClear && 32'(clrIdx) == f) shadow[f] <= '0;
      end
      if (state == StClear) clrIdx <= clrIdx + 1'b1;
      else                  clrIdx <= '0;
      if (state == StCommit) active <= shadowBits;
      Rb_valid <= Rb_req;
      Rb_data  <= (Rb_req && rbInRange) ? rbFrameData : '0;
      Err      <= Err | strobeErr | (Rb_req && !rbInRange);
    end
  end

  assign ConfigBits   = active;
  assign ConfigBits_N = ~active;

endmodule

// File: tb/tb_frame_shadow_config_mem.sv
// Directed bench for frame_shadow_config_mem; readback results are checked through an
// expectation queue, everything else against constants at each step.
module tb_frame_shadow_config_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  fd;
  logic [19:0]  fs;
  logic         cReq, clrReq, rbReq;
  logic [4:0]   rbFrame;
  logic         ack, busy, rbValid, err;
  logic [31:0]  rbData;
  logic [639:0] cfg, cfgN;

  logic [31:0]  sFd;
  logic [19:0]  sFs;
  logic         sCReq, sClrReq, sRbReq;
  logic [4:0]   sRbFrame;
  logic         sAck, sBusy, sRbValid, sErr;
  logic [31:0]  sRbData;
  logic [39:0]  sCfg, sCfgN;

  int tests = 0;
  int fails = 0;
  int n;

  typedef struct { string tag; logic [31:0] val; } rbExpT;
  rbExpT rbQ[$];

  frame_shadow_config_mem dut (
    .CLK(clk), .reset(rst), .FrameData(fd), .FrameStrobe(fs),
    .Commit_req(cReq), .Commit_ack(ack), .Clear_req(clrReq), .Busy(busy),
    .Rb_req(rbReq), .Rb_frame(rbFrame), .Rb_data(rbData), .Rb_valid(rbValid),
    .Err(err), .ConfigBits(cfg), .ConfigBits_N(cfgN)
  );

  frame_shadow_config_mem #(.NoConfigBits(40)) dutS (
    .CLK(clk), .reset(rst), .FrameData(sFd), .FrameStrobe(sFs),
    .Commit_req(sCReq), .Commit_ack(sAck), .Clear_req(sClrReq), .Busy(sBusy),
    .Rb_req(sRbReq), .Rb_frame(sRbFrame), .Rb_data(sRbData), .Rb_valid(sRbValid),
    .Err(sErr), .ConfigBits(sCfg), .ConfigBits_N(sCfgN)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expectRb(string tag, logic [31:0] v);
    rbExpT e;
    e.tag = tag;
    e.val = v;
    rbQ.push_back(e);
  endtask

  // One clock edge, then sample; a pending readback expectation must appear now.
  task automatic tick();
    rbExpT e;
    @(posedge clk);
    #1;
    if (rbQ.size() != 0) begin
      e = rbQ.pop_front();
      chkb({e.tag, "_valid"}, rbValid, 1'b1);
      chk(e.tag, rbData, e.val);
    end else begin
      chkb("rb_spurious_valid", rbValid, 1'b0);
    end
  endtask

  task automatic commit();
    cReq = 1'b1; tick(); tick();
    cReq = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; fd = '0; fs = '0; cReq = 1'b0; clrReq = 1'b0; rbReq = 1'b0; rbFrame = '0;
    sFd = '0; sFs = '0; sCReq = 1'b0; sClrReq = 1'b0; sRbReq = 1'b0; sRbFrame = '0;
    tick(); tick();
    chk("rst_cfg_lo", cfg[31:0], 32'h0);
    chkb("rst_cfgN_all1", &cfgN, 1'b1);
    chkb("rst_ack", ack, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_rbdata", rbData, 32'h0);
    chkb("rst_err", err, 1'b0);
    rst = 1'b0;

    // Reduced-width instance: only 40 bits stored.
    sFs = 20'h2; sFd = 32'hFFFF_FFFF; tick();
    sFs = '0; sCReq = 1'b1; tick(); tick();
    chk("s_cfg_hi", {24'h0, sCfg[39:32]}, 32'h0000_00FF);
    chk("s_cfg_lo", sCfg[31:0], 32'h0);
    chkb("s_inv", sCfgN === ~sCfg, 1'b1);
    sRbReq = 1'b1; sRbFrame = 5'd1; tick();
    chkb("s_rb_valid", sRbValid, 1'b1);
    chk("s_rb_frame1", sRbData, 32'h0000_00FF);
    chkb("s_ack_held", sAck, 1'b1);
    sRbReq = 1'b0; sCReq = 1'b0; tick();
    chkb("s_ack_drop", sAck, 1'b0);
    chkb("s_err", sErr, 1'b0);
    chkb("s_busy", sBusy, 1'b0);

    // Write two frames, commit.
    fs = 20'h1; fd = 32'hDEAD_BEEF; tick();
    fs = 20'h8_0000; fd = 32'h1234_5678; tick();
    fs = '0;
    chk("precommit_cfg", cfg[31:0], 32'h0);
    cReq = 1'b1; tick();
    chkb("commit_busy", busy, 1'b1);
    chkb("commit_ack_early", ack, 1'b0);
    tick();
    chkb("commit_ack", ack, 1'b1);
    chk("commit_f0", cfg[31:0], 32'hDEAD_BEEF);
    chk("commit_f19", cfg[639:608], 32'h1234_5678);
    chkb("commit_inv", cfgN === ~cfg, 1'b1);
    cReq = 1'b0; tick();
    chkb("ack_drop", ack, 1'b0);
    chkb("err_clean", err, 1'b0);

    // Readback, including read of a frame written on the same edge.
    rbReq = 1'b1; rbFrame = 5'd0; expectRb("rb_f0", 32'hDEAD_BEEF); tick();
    fs = 20'h1; fd = 32'h0; expectRb("rb_f0_prewrite", 32'hDEAD_BEEF); tick();
    fs = '0; expectRb("rb_f0_postwrite", 32'h0); tick();
    rbReq = 1'b0; tick();
    chkb("err_before_bad_rb", err, 1'b0);
    rbReq = 1'b1; rbFrame = 5'd25; expectRb("rb_bad_index", 32'h0); tick();
    rbReq = 1'b0;
    chkb("err_bad_rb", err, 1'b1);

    // Multi-bit strobe is rejected, later legal writes still land.
    rst = 1'b1; tick(); rst = 1'b0;
    chkb("err_after_rst", err, 1'b0);
    fs = 20'h1; fd = 32'h1111_1111; tick();
    fs = 20'h2; fd = 32'h2222_2222; tick();
    fs = 20'h3; fd = 32'hFFFF_FFFF; tick();
    chkb("err_multistrobe", err, 1'b1);
    fs = 20'h4; fd = 32'h3333_3333; tick();
    fs = '0;
    rbReq = 1'b1; rbFrame = 5'd0; expectRb("rb_multi_f0", 32'h1111_1111); tick();
    rbFrame = 5'd1; expectRb("rb_multi_f1", 32'h2222_2222); tick();
    rbFrame = 5'd2; expectRb("rb_legal_f2", 32'h3333_3333); tick();
    rbReq = 1'b0;

    // Sequenced clear.
    rst = 1'b1; tick(); rst = 1'b0;
    fs = 20'h1; fd = 32'h1111_1111; tick();
    fs = 20'h8_0000; fd = 32'h0000_0077; tick();
    fs = '0;
    commit();
    chk("preclear_f0", cfg[31:0], 32'h1111_1111);
    chkb("preclear_err", err, 1'b0);
    clrReq = 1'b1; tick();
    clrReq = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      rbReq = (i == 3);
      rbFrame = 5'd19;
      if (i == 3) expectRb("rb_during_clear", 32'h0000_0077);
      fs = (i == 10) ? 20'h1 : 20'h0;
      fd = 32'hFFFF_FFFF;
      tick();
    end
    rbReq = 1'b0; fs = '0;
    chk("clear_busy_cycles", n, 32'd20);
    chkb("clear_write_err", err, 1'b1);
    chk("clear_active_kept", cfg[31:0], 32'h1111_1111);
    rbReq = 1'b1; rbFrame = 5'd0; expectRb("rb_cleared_f0", 32'h0); tick();
    rbFrame = 5'd19; expectRb("rb_cleared_f19", 32'h0); tick();
    rbReq = 1'b0;
    commit();
    chk("postclear_f0", cfg[31:0], 32'h0);
    chk("postclear_f19", cfg[639:608], 32'h0);
    chkb("postclear_inv", &cfgN, 1'b1);

    // Commit and clear together with a frame write.
    cReq = 1'b1; clrReq = 1'b1; fs = 20'h8; fd = 32'hA5A5_A5A5; tick();
    clrReq = 1'b0; fs = '0;
    chkb("both_busy", busy, 1'b1);
    tick();
    chkb("both_ack", ack, 1'b1);
    chk("both_f3", cfg[127:96], 32'hA5A5_A5A5);
    tick();
    chkb("both_ack_held", ack, 1'b1);
    chkb("both_no_clear", busy, 1'b0);
    cReq = 1'b0; tick();
    chkb("both_ack_drop", ack, 1'b0);
    tick();
    chkb("both_idle", busy, 1'b0);
    rbReq = 1'b1; rbFrame = 5'd3; expectRb("rb_both_f3", 32'hA5A5_A5A5); tick();
    rbReq = 1'b0;

    // Reset in the middle of a clear, with a readback and commit request pending.
    clrReq = 1'b1; tick();
    clrReq = 1'b0; tick(); tick();
    chkb("midclear_busy", busy, 1'b1);
    rst = 1'b1; rbReq = 1'b1; rbFrame = 5'd3; cReq = 1'b1; tick();
    rbReq = 1'b0;
    chkb("rst_mid_busy", busy, 1'b0);
    chkb("rst_mid_ack", ack, 1'b0);
    chk("rst_mid_rbdata", rbData, 32'h0);
    chkb("rst_mid_err", err, 1'b0);
    chkb("rst_mid_cfg", |cfg, 1'b0);
    chkb("rst_mid_cfgN", &cfgN, 1'b1);
    rst = 1'b0; tick();
    chkb("resample_busy", busy, 1'b1);
    tick();
    chkb("resample_ack", ack, 1'b1);
    cReq = 1'b0; tick();
    chkb("resample_ack_drop", ack, 1'b0);

    chk("rb_queue_empty", rbQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
